// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle of the console UART receiver: show-ahead FIFO head, pop handshake and status pulses.
interface uart_rx_fifo_if #(parameter int DEPTH = 16);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic          frame_err;
   logic          overrun;
   logic [LW-1:0] level;

   modport master (output rd_data, rd_valid, frame_err, overrun, level, input rd_ready);
   modport slave  (input rd_data, rd_valid, frame_err, overrun, level, output rd_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote, feeding a show-ahead byte FIFO.
module uart_rx_fifo #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200,
   parameter int DIV      = CLK_FREQ / (BAUD * 16),
   parameter int DEPTH    = 16
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           rx,
   uart_rx_fifo_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(DIV);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t        state_q, state_d;
   logic          rx_meta, rxs;
   logic [TW-1:0] tcnt;
   logic          tick, tick_clr;
   logic [3:0]    s;
   logic          v7, v8, maj, dec;
   logic [2:0]    bidx;
   logic [7:0]    shreg;
   logic          push, ferr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // Free-running oversample divider, re-phased to the start edge so samples land mid-bit.
   assign tick = (tcnt == TW'(DIV - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                tcnt <= '0;
      else if (tick_clr || tick) tcnt <= '0;
      else                      tcnt <= tcnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)         s <= '0;
      else if (tick_clr) s <= '0;
      else if (tick)     s <= s + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v7 <= 1'b1;
         v8 <= 1'b1;
      end else begin
         if (tick && s == 4'd7) v7 <= rxs;
         if (tick && s == 4'd8) v8 <= rxs;
      end
   end

   assign dec = tick && (s == 4'd9);
   assign maj = (v7 & v8) | (v7 & rxs) | (v8 & rxs);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      tick_clr = 1'b0;
      push     = 1'b0;
      ferr     = 1'b0;
      case (state_q)
         IDLE:  if (!rxs) begin
                   state_d  = START;
                   tick_clr = 1'b1;
                end
         START: if (dec) state_d = maj ? IDLE : DATA;
         DATA:  if (dec && bidx == 3'd7) state_d = STOP;
         STOP:  if (dec) begin
                   if (maj) begin
                      push    = 1'b1;
                      state_d = IDLE;
                   end else begin
                      ferr    = 1'b1;
                      state_d = BRK;
                   end
                end
         BRK:   if (rxs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bidx  <= '0;
         shreg <= '0;
      end else if (state_q == START) begin
         bidx <= '0;
      end else if (state_q == DATA && dec) begin
         bidx  <= bidx + 1'b1;
         shreg <= {maj, shreg[7:1]};
      end
   end

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wp, rp;
   logic        empty, full, pop, wr_en;
   logic        ferr_q, ovr_q;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop   = !empty && bus.rd_ready;
   // A pop in the same cycle frees the head slot, so a full FIFO can still take the byte.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wp[AW-1:0]] <= shreg;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wp     <= '0;
         rp     <= '0;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         if (wr_en) wp <= wp + 1'b1;
         if (pop)   rp <= rp + 1'b1;
         ferr_q <= ferr;
         ovr_q  <= push && full && !pop;
      end
   end

   assign bus.rd_valid  = !empty;
   assign bus.rd_data   = empty ? 8'h00 : mem[rp[AW-1:0]];
   assign bus.level     = wp - rp;
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;
endmodule
